// File: rtl/butterfly_output_buffer.sv
// butterfly_output_buffer: scales and saturates butterfly results into a two-bank ping-pong
// buffer, then streams each frame out as four (plus, minus) beats under valid/ready.
module butterfly_output_buffer #(
  parameter int p_inputWidth = 8,
  parameter int p_PointPosition = 3,
  parameter int p_shift = 1,
  localparam int M = 2*p_inputWidth - p_PointPosition + 1,
  localparam int W = p_inputWidth
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           i_frameDone,
  input  logic [2*M-1:0] i_r1_p,
  input  logic [2*M-1:0] i_r1_m,
  input  logic [2*M-1:0] i_r2_p,
  input  logic [2*M-1:0] i_r2_m,
  input  logic [2*M-1:0] i_r3_p,
  input  logic [2*M-1:0] i_r3_m,
  input  logic [2*M-1:0] i_r4_p,
  input  logic [2*M-1:0] i_r4_m,
  input  logic           i_ready,
  output logic           o_valid,
  output logic [2*W-1:0] o_sumP,
  output logic [2*W-1:0] o_diffM,
  output logic [1:0]     o_idx,
  output logic           o_last,
  output logic           o_satFlag,
  output logic           o_overflow
);
  localparam int RND = (1 << p_shift) >> 1;
  localparam logic signed [M:0] HI = (M+1)'(2**(W-1) - 1);
  localparam logic signed [M:0] LO = ~HI;
  // {clip, value}: round-half-up shift in M+1 bits, then clamp to W bits
  function automatic logic [W:0] cvt(input logic [M-1:0] x);
    logic signed [M:0] t;
    t = ($signed({x[M-1], x}) + $signed((M+1)'(RND))) >>> p_shift;
    return t > HI ? {1'b1, HI[W-1:0]} : t < LO ? {1'b1, LO[W-1:0]} : {1'b0, t[W-1:0]};
  endfunction
  function automatic logic [2*W:0] cvt_word(input logic [2*M-1:0] w);
    logic [W:0] re, im;
    re = cvt(w[2*M-1:M]);
    im = cvt(w[M-1:0]);
    return {re[W] | im[W], re[W-1:0], im[W-1:0]};
  endfunction
  logic [2*W:0] cp [4];
  logic [2*W:0] cm [4];
  logic [2*W:0] bp [2][4];
  logic [2*W:0] bm [2][4];
  logic [2*W:0] cur_p, cur_m;
  logic [1:0] cnt, idx;
  logic wp, rd, ovf, xfer, rel, acc;
  always_comb begin
    cp[0] = cvt_word(i_r1_p);
    cp[1] = cvt_word(i_r2_p);
    cp[2] = cvt_word(i_r3_p);
    cp[3] = cvt_word(i_r4_p);
    cm[0] = cvt_word(i_r1_m);
    cm[1] = cvt_word(i_r2_m);
    cm[2] = cvt_word(i_r3_m);
    cm[3] = cvt_word(i_r4_m);
  end
  assign o_valid = cnt != 2'd0;
  assign xfer = o_valid & i_ready;
  assign rel = xfer & (idx == 2'd3);
  // a full buffer can still take a frame if the oldest one finishes this cycle
  assign acc = i_frameDone & ((cnt < 2'd2) | rel);
  assign cur_p = bp[rd][idx];
  assign cur_m = bm[rd][idx];
  assign o_sumP = o_valid ? cur_p[2*W-1:0] : '0;
  assign o_diffM = o_valid ? cur_m[2*W-1:0] : '0;
  assign o_satFlag = o_valid & (cur_p[2*W] | cur_m[2*W]);
  assign o_idx = idx;
  assign o_last = o_valid & (idx == 2'd3);
  assign o_overflow = ovf;
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
      wp <= 1'b0;
      rd <= 1'b0;
      idx <= '0;
      ovf <= 1'b0;
    end else begin
      cnt <= cnt + 2'(acc) - 2'(rel);
      if (acc) wp <= ~wp;
      if (i_frameDone & ~acc) ovf <= 1'b1;
      if (xfer) idx <= idx + 2'd1;
      if (rel) rd <= ~rd;
    end
    if (acc) for (int k = 0; k < 4; k++) begin
      bp[wp][k] <= cp[k];
      bm[wp][k] <= cm[k];
    end
  end
endmodule

// File: tb/tb_butterfly_output_buffer.sv
// tb_butterfly_output_buffer: randomized bench against a frame-queue reference model.
module tb_butterfly_output_buffer;
  localparam int W = 8, P = 3, S = 1, M = 2*W - P + 1;
  localparam int HI = (1 << (W-1)) - 1;
  logic CLK = 1'b0, RST = 1'b1, i_frameDone = 1'b0, i_ready = 1'b0;
  logic [2*M-1:0] din [8];
  logic o_valid, o_last, o_satFlag, o_overflow;
  logic [2*W-1:0] o_sumP, o_diffM;
  logic [1:0] o_idx;
  int errors = 0, checks = 0;
  typedef struct {
    logic [2*W-1:0] p [4];
    logic [2*W-1:0] m [4];
    logic s [4];
  } frame_t;
  frame_t fq[$];
  int pos = 0;
  bit ovf = 1'b0;
  always #5 CLK = ~CLK;
  butterfly_output_buffer #(.p_inputWidth(W), .p_PointPosition(P), .p_shift(S)) dut (
    .CLK(CLK), .RST(RST), .i_frameDone(i_frameDone),
    .i_r1_p(din[0]), .i_r1_m(din[1]), .i_r2_p(din[2]), .i_r2_m(din[3]),
    .i_r3_p(din[4]), .i_r3_m(din[5]), .i_r4_p(din[6]), .i_r4_m(din[7]),
    .i_ready(i_ready), .o_valid(o_valid), .o_sumP(o_sumP), .o_diffM(o_diffM),
    .o_idx(o_idx), .o_last(o_last), .o_satFlag(o_satFlag), .o_overflow(o_overflow)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int ref_cvt(input int x, output bit s);
    int y;
    y = S == 0 ? x : (x + (1 << (S-1))) >>> S;
    s = y > HI || y < -HI-1;
    return y > HI ? HI : y < -HI-1 ? -HI-1 : y;
  endfunction
  function automatic logic [2*W:0] ref_word(input logic [2*M-1:0] w);
    bit sr, si;
    int yr, yi;
    yr = ref_cvt(int'($signed(w[2*M-1:M])), sr);
    yi = ref_cvt(int'($signed(w[M-1:0])), si);
    return {sr | si, W'(yr), W'(yi)};
  endfunction
  function automatic logic [2*M-1:0] pk(input int re, input int im);
    return {M'(re), M'(im)};
  endfunction
  task automatic rand_data(input bit big);
    for (int j = 0; j < 8; j++)
      din[j] = big ? pk(int'($urandom_range((1 << M) - 1)) - (1 << (M-1)),
                        int'($urandom_range((1 << M) - 1)) - (1 << (M-1)))
                   : pk(int'($urandom_range(400)) - 200, int'($urandom_range(400)) - 200);
  endtask
  task automatic step(input bit fd, input bit rdy, input bit rst);
    bit rel, acc, v;
    frame_t f;
    logic [2*W:0] w;
    i_frameDone = fd;
    i_ready = rdy;
    RST = rst;
    if (rst) begin
      fq.delete();
      pos = 0;
      ovf = 1'b0;
    end else begin
      rel = fq.size() > 0 && rdy && pos == 3;
      acc = fd && (fq.size() < 2 || (fq.size() == 2 && rel));
      for (int k = 0; k < 4; k++) begin
        w = ref_word(din[2*k]);
        f.p[k] = w[2*W-1:0];
        f.s[k] = w[2*W];
        w = ref_word(din[2*k+1]);
        f.m[k] = w[2*W-1:0];
        f.s[k] = f.s[k] | w[2*W];
      end
      if (fq.size() > 0 && rdy) begin
        if (pos == 3) begin
          fq.delete(0);
          pos = 0;
        end else pos++;
      end
      if (acc) fq.push_back(f);
      else if (fd) ovf = 1'b1;
    end
    @(posedge CLK);
    @(negedge CLK);
    v = fq.size() > 0;
    chk("valid", o_valid, v);
    chk("idx", o_idx, pos);
    chk("last", o_last, v && pos == 3);
    chk("overflow", o_overflow, ovf);
    if (v) begin
      chk("sumP", o_sumP, fq[0].p[pos]);
      chk("diffM", o_diffM, fq[0].m[pos]);
      chk("satFlag", o_satFlag, fq[0].s[pos]);
    end else begin
      chk("sumP_idle", o_sumP, 0);
      chk("diffM_idle", o_diffM, 0);
      chk("sat_idle", o_satFlag, 0);
    end
  endtask
  initial begin
    bit hit;
    for (int j = 0; j < 8; j++) din[j] = '0;
    step(0, 0, 1);
    step(0, 0, 1);
    rand_data(0);
    din[0] = pk(100, -3);
    din[3] = pk(300, -300);
    step(1, 1, 0);
    chk("beat0_sumP", o_sumP, 16'h32FF);
    chk("beat0_sat", o_satFlag, 0);
    step(0, 1, 0);
    chk("beat1_diffM", o_diffM, 16'h7F80);
    chk("beat1_sat", o_satFlag, 1);
    repeat (4) step(0, 1, 0);
    rand_data(1);
    step(1, 0, 0);
    repeat (6) begin
      step(0, 0, 0);
      chk("bp_idx", o_idx, 0);
    end
    repeat (5) step(0, 1, 0);
    for (int n = 0; n < 3; n++) begin
      rand_data(1);
      step(1, 0, 0);
      if (n < 2) repeat (4) step(0, 0, 0);
    end
    chk("ovf_set", o_overflow, 1);
    repeat (9) step(0, 1, 0);
    chk("ovf_drained", o_valid, 0);
    step(0, 0, 1);
    chk("ovf_cleared", o_overflow, 0);
    rand_data(1);
    step(1, 0, 0);
    rand_data(1);
    step(1, 0, 0);
    hit = 0;
    for (int c = 0; c < 10 && !hit; c++) begin
      if (fq.size() == 2 && pos == 3) begin
        rand_data(1);
        step(1, 1, 0);
        hit = 1;
      end else step(0, 1, 0);
    end
    chk("bnd_reached", hit, 1);
    chk("bnd_no_ovf", o_overflow, 0);
    repeat (9) step(0, 1, 0);
    rand_data(0);
    step(1, 0, 0);
    step(1, 0, 0);
    hit = 0;
    for (int c = 0; c < 10 && !hit; c++) begin
      if (fq.size() == 2 && pos == 2) hit = 1;
      else step(0, 1, 0);
    end
    chk("midrst_reached", hit, 1);
    step(0, 1, 1);
    chk("midrst_valid", o_valid, 0);
    chk("midrst_ovf", o_overflow, 0);
    rand_data(1);
    step(1, 1, 0);
    chk("fresh_idx", o_idx, 0);
    repeat (4) step(0, 1, 0);
    repeat (3000) begin
      rand_data($urandom_range(1) == 1);
      step($urandom_range(9) < 3, $urandom_range(9) < 7, $urandom_range(499) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
